rom_read_arbiter: RTL and testbench

//  Shares the single read port of one 512x8 ROM (SB_RAM40_4KNRNW, 8-bit read mode) among

---
 rtl/rom_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Round-robin arbiter sharing the single read port of a 512x8 ROM
// (SB_RAM40_4KNRNW in 8-bit read mode) among NREQ requesters.
// One grant per cycle, fixed 1-cycle read latency, and an optional bounded
// lock that lets a requester keep the port for up to LOCK_MAX back-to-back
// reads before it has to take its turn again.
// In 8-bit mode the RAM places the data byte on the even RDATA bits; the
// odd bits carry nothing useful and are ignored.

module rom_read_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 9,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               resetq,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [7:0]         rdata,
  output logic [10:0]        rom_raddr,
  output logic               rom_re,
  input  logic [15:0]        rom_rdata
);

  // Index width for requester numbers (at least one bit).
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W     = (IW + 1)'(NREQ);
  localparam logic [7:0]    LOCK_MAX_C = 8'(LOCK_MAX);

  // Arbitration state.
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic            owner_valid_reg, owner_valid_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [7:0]      lock_cnt_reg, lock_cnt_next;
  logic [NREQ-1:0] rvalid_reg;

  // Combinational arbitration results.
  logic            any_req;
  logic            owner_hold;
  logic            rr_found;
  logic [IW-1:0]   rr_idx;
  logic [IW:0]     cand_w;
  logic [IW-1:0]   winner;

  // Per-requester address view of the packed address bus.
  logic [AW-1:0]   addr_arr [NREQ];

  // Odd RDATA bits are not part of the byte in 8-bit read mode.
  logic [7:0]      unused_odd_bits;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = addr[gi*AW +: AW];
      // Only the winner's bit is ever set, and only while somebody requests.
      assign gnt[gi]      = any_req && (winner == IW'(gi));
    end
  endgenerate

  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign rdata[gi]           = rom_rdata[2*gi];
      assign unused_odd_bits[gi] = rom_rdata[2*gi+1];
    end
  endgenerate

  assign any_req = |req;

  // A locked owner keeps the port only while it still asks and is under its budget.
  assign owner_hold = owner_valid_reg && req[owner_reg] && (lock_cnt_reg < LOCK_MAX_C);

  // Round-robin scan: first requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr_reg;
    cand_w   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_w = {1'b0, rr_ptr_reg} + (IW + 1)'(k);
      if (cand_w >= NREQ_W) begin
        cand_w = cand_w - NREQ_W;
      end
      if (!rr_found && req[cand_w[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand_w[IW-1:0];
      end
    end
  end

  assign winner = owner_hold ? owner_reg : rr_idx;

  // RAM read port: address of the winner, zero-extended; parked at 0 when idle.
  assign rom_re    = any_req;
  assign rom_raddr = any_req ? 11'(addr_arr[winner]) : 11'h000;

  assign rvalid = rvalid_reg;

  // Next pointer / lock ownership after this cycle's grant (or lack of one).
  always_comb begin
    rr_ptr_next      = rr_ptr_reg;
    owner_valid_next = owner_valid_reg;
    owner_next       = owner_reg;
    lock_cnt_next    = lock_cnt_reg;
    if (any_req) begin
      rr_ptr_next = (winner == LAST_IDX) ? '0 : winner + IW'(1);
      if (lock[winner]) begin
        if (owner_valid_reg && (owner_reg == winner) && (lock_cnt_reg < LOCK_MAX_C)) begin
          // Continuing an existing burst.
          lock_cnt_next = lock_cnt_reg + 8'd1;
        end else begin
          // New burst, or the old owner won again through round-robin after
          // exhausting its budget: the count restarts.
          owner_valid_next = 1'b1;
          owner_next       = winner;
          lock_cnt_next    = 8'd1;
        end
      end else begin
        owner_valid_next = 1'b0;
        lock_cnt_next    = 8'd0;
      end
    end else begin
      // Nobody requests, so any owner has dropped its request: release the lock.
      owner_valid_next = 1'b0;
      lock_cnt_next    = 8'd0;
    end
  end

  // State registers; rvalid tracks the grant one cycle later, matching the RAM latency.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rr_ptr_reg      <= '0;
      owner_valid_reg <= 1'b0;
      owner_reg       <= '0;
      lock_cnt_reg    <= 8'd0;
      rvalid_reg      <= '0;
    end else begin
      rr_ptr_reg      <= rr_ptr_next;
      owner_valid_reg <= owner_valid_next;
      owner_reg       <= owner_next;
      lock_cnt_reg    <= lock_cnt_next;
      rvalid_reg      <= gnt;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
// Directed scenarios plus a constrained-random run for rom_read_arbiter.
// A behavioural model of the 512x8 ROM supplies RDATA with the byte on the
// even bits and its complement on the odd bits.

module tb_rom_read_arbiter;

  localparam int NREQ       = 3;
  localparam int AW         = 9;
  localparam int LOCK_MAX   = 8;
  localparam int STARVE_MAX = (NREQ - 1) * LOCK_MAX + NREQ;

  logic               clk = 1'b0;
  logic               resetq = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ-1:0]    lock = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [7:0]         rdata;
  logic [10:0]        rom_raddr;
  logic               rom_re;
  logic [15:0]        rom_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  rom_read_arbiter #(.NREQ(NREQ), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .resetq    (resetq),
    .req       (req),
    .addr      (addr),
    .lock      (lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rom_raddr (rom_raddr),
    .rom_re    (rom_re),
    .rom_rdata (rom_rdata)
  );

  always #5 clk = ~clk;

  // ROM image contents.
  function automatic logic [7:0] rom_byte(input logic [8:0] a);
    return (a[7:0] * 8'd13 + 8'h29) ^ {a[8], a[8], 6'b000000};
  endfunction

  // 8-bit read mode word: byte on even bits, complement on odd bits.
  function automatic logic [15:0] rom_word(input logic [8:0] a);
    logic [7:0]  b;
    logic [15:0] w;
    b = rom_byte(a);
    w = '0;
    for (int k = 0; k < 8; k++) begin
      w[2*k]   = b[k];
      w[2*k+1] = ~b[k];
    end
    return w;
  endfunction

  // Registered RAM read port.
  always @(posedge clk) begin
    if (rom_re) rom_rdata <= rom_word(rom_raddr[8:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [8:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    req    = '0;
    lock   = '0;
    step();
    step();
    resetq = 1'b1;
  endtask

  task automatic test_reset();
    req  = '0;
    lock = '0;
    step();
    #1;
    n_checks++; if (rvalid !== 3'b000) $display("FAIL reset_rvalid: got %b expected 000", rvalid); else n_pass++;
    n_checks++; if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b expected 000", gnt); else n_pass++;
    n_checks++; if (rom_re !== 1'b0) $display("FAIL reset_rom_re: got %b expected 0", rom_re); else n_pass++;
    n_checks++; if (rom_raddr !== 11'h000) $display("FAIL reset_raddr: got %h expected 000", rom_raddr); else n_pass++;
    $display("[reset] rvalid=%b gnt=%b rom_re=%b", rvalid, gnt, rom_re);
    resetq = 1'b1;
  endtask

  task automatic test_single();
    step();
    req = 3'b001;
    set_addr(0, 9'h005);
    #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL single_gnt: got %b expected 001", gnt); else n_pass++;
    n_checks++; if (rom_raddr !== 11'h005) $display("FAIL single_raddr: got %h expected 005", rom_raddr); else n_pass++;
    n_checks++; if (rom_re !== 1'b1) $display("FAIL single_rom_re: got %b expected 1", rom_re); else n_pass++;
    step();
    req = 3'b000;
    #1;
    n_checks++; if (rvalid !== 3'b001) $display("FAIL single_rvalid: got %b expected 001", rvalid); else n_pass++;
    n_checks++; if (rdata !== rom_byte(9'h005)) $display("FAIL single_rdata: got %h expected %h", rdata, rom_byte(9'h005)); else n_pass++;
    n_checks++; if (gnt !== 3'b000) $display("FAIL single_idle_gnt: got %b expected 000", gnt); else n_pass++;
    n_checks++; if (rom_raddr !== 11'h000) $display("FAIL single_idle_raddr: got %h expected 000", rom_raddr); else n_pass++;
    $display("[single] addr=005 rvalid=%b rdata=%h", rvalid, rdata);
    step();
    #1;
    n_checks++; if (rvalid !== 3'b000) $display("FAIL single_rvalid_drop: got %b expected 000", rvalid); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [8:0] a [3] = '{9'h000, 9'h101, 9'h1FF};
    int prev = -1;
    int ei;
    do_reset();
    for (int i = 0; i < 3; i++) set_addr(i, a[i]);
    for (int c = 0; c < 6; c++) begin
      req  = 3'b111;
      lock = 3'b000;
      #1;
      ei = c % 3;
      n_checks++; if (gnt !== 3'(1 << ei)) $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, 3'(1 << ei)); else n_pass++;
      n_checks++; if (rom_raddr !== {2'b00, a[ei]}) $display("FAIL rr_raddr c%0d: got %h expected %h", c, rom_raddr, {2'b00, a[ei]}); else n_pass++;
      if (prev >= 0) begin
        n_checks++; if (rvalid !== 3'(1 << prev)) $display("FAIL rr_rvalid c%0d: got %b expected %b", c, rvalid, 3'(1 << prev)); else n_pass++;
        n_checks++; if (rdata !== rom_byte(a[prev])) $display("FAIL rr_rdata c%0d: got %h expected %h", c, rdata, rom_byte(a[prev])); else n_pass++;
      end
      $display("[rr] c=%0d req=%b gnt=%b rvalid=%b rdata=%h", c, req, gnt, rvalid, rdata);
      prev = ei;
      step();
    end
    req = 3'b000;
    #1;
    n_checks++; if (rvalid !== 3'b100) $display("FAIL rr_last_rvalid: got %b expected 100", rvalid); else n_pass++;
    n_checks++; if (rdata !== rom_byte(a[2])) $display("FAIL rr_last_rdata: got %h expected %h", rdata, rom_byte(a[2])); else n_pass++;
    step();
  endtask

  task automatic test_lock_burst();
    logic [8:0] a [3] = '{9'h033, 9'h144, 9'h0F5};
    int exp_idx [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 1, 1};
    int prev = -1;
    do_reset();
    for (int i = 0; i < 3; i++) set_addr(i, a[i]);
    for (int c = 0; c < 13; c++) begin
      req  = (c == 0) ? 3'b001 : 3'b111;
      lock = (c == 0) ? 3'b000 : 3'b010;
      #1;
      n_checks++; if (gnt !== 3'(1 << exp_idx[c])) $display("FAIL lock_gnt c%0d: got %b expected %b", c, gnt, 3'(1 << exp_idx[c])); else n_pass++;
      if (prev >= 0) begin
        n_checks++; if (rvalid !== 3'(1 << prev)) $display("FAIL lock_rvalid c%0d: got %b expected %b", c, rvalid, 3'(1 << prev)); else n_pass++;
        n_checks++; if (rdata !== rom_byte(a[prev])) $display("FAIL lock_rdata c%0d: got %h expected %h", c, rdata, rom_byte(a[prev])); else n_pass++;
      end
      $display("[lock] c=%0d req=%b lock=%b gnt=%b rvalid=%b rdata=%h", c, req, lock, gnt, rvalid, rdata);
      prev = exp_idx[c];
      step();
    end
    req  = 3'b000;
    lock = 3'b000;
    step();
  endtask

  // Owner alone exhausts its budget, re-wins with the count restarted, then
  // must still give way after exactly LOCK_MAX total grants of the new burst.
  task automatic test_lock_solo();
    int ei;
    for (int c = 0; c < 18; c++) begin
      req  = (c < 9) ? 3'b010 : 3'b111;
      lock = 3'b010;
      #1;
      ei = (c < 16) ? 1 : ((c == 16) ? 2 : 0);
      n_checks++; if (gnt !== 3'(1 << ei)) $display("FAIL solo_gnt c%0d: got %b expected %b", c, gnt, 3'(1 << ei)); else n_pass++;
      $display("[solo] c=%0d req=%b lock=%b gnt=%b", c, req, lock, gnt);
      step();
    end
    req  = 3'b000;
    lock = 3'b000;
    step();
  endtask

  task automatic test_lock_release();
    logic [2:0] req_tab  [9] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110};
    logic [2:0] lock_tab [9] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    int exp_idx [9] = '{0, 0, 0, -1, 1, 2, 0, 1, 2};
    logic [8:0] a [3] = '{9'h077, 9'h188, 9'h0C9};
    logic [2:0]  exp_g;
    logic [10:0] exp_ra;
    int prev = -1;
    do_reset();
    for (int i = 0; i < 3; i++) set_addr(i, a[i]);
    for (int c = 0; c < 9; c++) begin
      req  = req_tab[c];
      lock = lock_tab[c];
      #1;
      exp_g  = (exp_idx[c] < 0) ? 3'b000 : 3'(1 << exp_idx[c]);
      exp_ra = (exp_idx[c] < 0) ? 11'h000 : {2'b00, a[exp_idx[c]]};
      n_checks++; if (gnt !== exp_g) $display("FAIL release_gnt c%0d: got %b expected %b", c, gnt, exp_g); else n_pass++;
      n_checks++; if (rom_raddr !== exp_ra) $display("FAIL release_raddr c%0d: got %h expected %h", c, rom_raddr, exp_ra); else n_pass++;
      n_checks++; if (rom_re !== (|req_tab[c])) $display("FAIL release_rom_re c%0d: got %b expected %b", c, rom_re, |req_tab[c]); else n_pass++;
      if (prev >= 0) begin
        n_checks++; if (rdata !== rom_byte(a[prev])) $display("FAIL release_rdata c%0d: got %h expected %h", c, rdata, rom_byte(a[prev])); else n_pass++;
      end
      $display("[release] c=%0d req=%b lock=%b gnt=%b rvalid=%b rdata=%h", c, req, lock, gnt, rvalid, rdata);
      prev = exp_idx[c];
      step();
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_read();
    step();
    req = 3'b001;
    set_addr(0, 9'h0AA);
    set_addr(2, 9'h155);
    #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL midrst_gnt0: got %b expected 001", gnt); else n_pass++;
    step();
    req = 3'b000;
    #1;
    n_checks++; if (rvalid !== 3'b001) $display("FAIL midrst_rvalid_before: got %b expected 001", rvalid); else n_pass++;
    resetq = 1'b0;
    #1;
    n_checks++; if (rvalid !== 3'b000) $display("FAIL midrst_rvalid_cleared: got %b expected 000", rvalid); else n_pass++;
    $display("[midrst] reset asserted rvalid=%b", rvalid);
    step();
    resetq = 1'b1;
    req = 3'b101;
    #1;
    n_checks++; if (gnt !== 3'b001) $display("FAIL midrst_rr_restart: got %b expected 001", gnt); else n_pass++;
    step();
    req = 3'b100;
    #1;
    n_checks++; if (gnt !== 3'b100) $display("FAIL midrst_gnt2: got %b expected 100", gnt); else n_pass++;
    n_checks++; if (rdata !== rom_byte(9'h0AA)) $display("FAIL midrst_rdata0: got %h expected %h", rdata, rom_byte(9'h0AA)); else n_pass++;
    step();
    req = 3'b000;
    #1;
    n_checks++; if (rvalid !== 3'b100) $display("FAIL midrst_rvalid2: got %b expected 100", rvalid); else n_pass++;
    n_checks++; if (rdata !== rom_byte(9'h155)) $display("FAIL midrst_rdata2: got %h expected %h", rdata, rom_byte(9'h155)); else n_pass++;
    $display("[midrst] after release rvalid=%b rdata=%h", rvalid, rdata);
    step();
  endtask

  // Random requesters obeying the hold-until-grant rule; checks legality,
  // read data and the starvation bound.
  task automatic test_random();
    logic [NREQ-1:0] gnt_q = '0;
    logic [8:0]      gaddr_q = '0;
    logic [8:0]      gaddr;
    logic [10:0]     exp_ra;
    logic            legal;
    int              wait_cnt [NREQ];
    int              max_wait = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || gnt_q[i]) begin
          req[i]  = ($urandom_range(0, 9) < 6);
          lock[i] = ($urandom_range(0, 9) < 4);
          set_addr(i, 9'($urandom_range(0, 511)));
        end
      end
      #1;
      legal = ((gnt & ~req) == '0) && $onehot0(gnt) && ((gnt != '0) == (req != '0));
      n_checks++; if (!legal) $display("FAIL rand_gnt_legal c%0d: got gnt=%b for req=%b", c, gnt, req); else n_pass++;
      n_checks++; if (rvalid !== gnt_q) $display("FAIL rand_rvalid c%0d: got %b expected %b", c, rvalid, gnt_q); else n_pass++;
      if (gnt_q != '0) begin
        n_checks++; if (rdata !== rom_byte(gaddr_q)) $display("FAIL rand_rdata c%0d: got %h expected %h", c, rdata, rom_byte(gaddr_q)); else n_pass++;
      end
      gaddr = '0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gaddr = addr[i*AW +: AW];
      exp_ra = (gnt != '0) ? {2'b00, gaddr} : 11'h000;
      n_checks++; if (rom_raddr !== exp_ra) $display("FAIL rand_raddr c%0d: got %h expected %h", c, rom_raddr, exp_ra); else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      gnt_q   = gnt;
      gaddr_q = gaddr;
      step();
    end
    n_checks++; if (max_wait > STARVE_MAX) $display("FAIL rand_starvation: got max wait %0d expected <= %0d", max_wait, STARVE_MAX); else n_pass++;
    $display("[random] 2000 cycles, max wait %0d", max_wait);
    req  = '0;
    lock = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_lock_solo();
    test_lock_release();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
